regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of dff_block_negedge_write between NUM_REQ writeback sources
//  (ALU, load unit, CSR, ...). Holds one pending write per source and grants one per cycle round-robin.
//  Drives we / one-hot wr_sel / data_in. Also runs a zero-scrub sweep of all entries after reset or on request.
//  Sits between the writeback stage and the register file.
// PARAMETERS
//  mem_width   32  data bits per entry (matches register file)
//  mem_depth   32  entries; AW = $clog2(mem_depth)
//  NUM_REQ     3   writeback sources, >=2
//  INIT_SCRUB  1   1: enter SCRUB after reset; 0: enter RUN directly
//  ZERO_REG    1   1: writes to address 0 are consumed but never asserted on rf_we
// PORTS
//  clk         in   1               clock
//  reset       in   1               asynchronous, active-high reset
//  req_valid   in   NUM_REQ         per-source write request
//  req_addr    in   NUM_REQ*AW      source i address at [i*AW +: AW]
//  req_data    in   NUM_REQ*W       source i data at [i*mem_width +: mem_width]
//  req_ready   out  NUM_REQ         slot i can accept this cycle
//  clear_req   in   1               pulse: start zero-scrub (sampled in RUN only)
//  busy        out  1               high in SCRUB or any slot occupied
//  rf_we       out  1               to register-file we
//  rf_wr_sel   out  mem_depth       one-hot entry select
//  rf_data_in  out  mem_width       write data
// BEHAVIOUR
//  - Reset (async): state=SCRUB if INIT_SCRUB else RUN; scrub_cnt=0, rr_ptr=0, all slots empty;
//    rf_we=0, rf_wr_sel=0, rf_data_in=0 while reset asserted; req_ready=0.
//  - FSM: SCRUB -> RUN when scrub_cnt==mem_depth-1 write issued; RUN -> SCRUB when clear_req=1 and no slot occupied;
//    clear_req with slots occupied is held pending (sticky) until slots drain, then SCRUB.
//  - SCRUB: rf_we=1, rf_wr_sel=onehot(scrub_cnt), rf_data_in=0; scrub_cnt++ each clk; mem_depth cycles total
//    (entry 0 included). req_ready=0 throughout; new clear_req ignored.
//  - Accept: slot i loads {addr,data} at posedge when req_valid[i]&req_ready[i].
//    req_ready[i] = (state==RUN) & !clear_pending & (!occ[i] | grant[i]) -> back-to-back per source, no bubble.
//  - Grant (RUN, combinational from registered slots only): first occupied slot scanning from rr_ptr upward, wrapping.
//    Granted slot drives rf_wr_sel=onehot(addr), rf_data_in=data, rf_we=1; register file captures at negedge
//    of the same cycle; slot freed at next posedge. Latency: handshake edge -> write at negedge of following cycle.
//  - rr_ptr <= (g+1) mod NUM_REQ after grant to g; unchanged when no grant.
//  - No slot occupied: rf_we=0, rf_wr_sel=0, rf_data_in=0.
//  - ZERO_REG=1 and granted addr==0: slot consumed and rr_ptr advances, but rf_we=0, rf_wr_sel=0.
//  - Addr >= mem_depth (non-power-of-2 depth): consumed, rf_we=0.
//  - Ordering: per source FIFO order is preserved; cross-source order to the same address is NOT guaranteed
//    (upstream scoreboard owns WAW). Simultaneous grant+refill on one slot: new entry lands, slot stays occupied.
//  - No combinational path from any req_* input to rf_* outputs or req_ready.
//  - busy = (state==SCRUB) | (|occ) | clear_pending.
// STRUCTURE
//  - regfile_pkg: state_e {SCRUB, RUN}; function addr_w(depth); onehot decode function.
//  - Sub-module rr_arbiter #(N): inputs occ[N], ptr; outputs grant[N] one-hot, grant_idx. Purely combinational.
//  - Top holds slots, FSM, scrub_cnt, rr_ptr, clear_pending, output mux.
// TESTING
//  1 Reset with INIT_SCRUB=1, depth 32 -> rf_we=1 for exactly 32 clks, wr_sel 0x1..0x8000_0000, data 0; then RUN, ready=3'b111.
//  2 All 3 sources valid same cycle, addr 5/6/7, data A/B/C, rr_ptr=0 -> writes entry5=A, 6=B, 7=C in 3 consecutive cycles; rr_ptr=0 after.
//  3 Source 1 streams 4 writes back-to-back alone -> ready[1] stays 1, one rf_we per cycle, 4 writes in order, no bubble.
//  4 Source 0 writes addr 0, data 0xFFFF_FFFF (ZERO_REG=1) -> slot consumed, rf_we never asserted, ready[0] returns 1.
//  5 clear_req while 2 slots occupied -> both writes complete, req_ready=0 from next cycle, then 32-cycle scrub, busy low after.
//  6 Assert reset mid-stream with slots full -> outputs 0 immediately (async), slots lost, scrub restarts from entry 0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Provides the FSM state constants, the address-width helper and a one-hot decoder.
package regfile_write_arbiter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_SCRUB = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  localparam int unsigned MAX_AW    = 10;
  localparam int unsigned MAX_DEPTH = 1 << MAX_AW;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Callers slice the low mem_depth bits of the result.
  function automatic logic [MAX_DEPTH-1:0] onehot(input int unsigned idx);
    logic [MAX_DEPTH-1:0] v;
    v = '0;
    if (idx < MAX_DEPTH) v[MAX_AW'(idx)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set bit of occ_i at or above ptr_i, wrapping.
// Returns a one-hot grant and its index.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = addr_w(N)
) (
  input  logic [N-1:0]  occ_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic          found;
  int unsigned   j;
  logic [IW-1:0] jj;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    jj          = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j  = (32'(ptr_i) + k) % N;
      jj = IW'(j);
      if (!found && occ_i[jj]) begin
        found       = 1'b1;
        grant_o[jj] = 1'b1;
        grant_idx_o = jj;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback sources (one slot each,
// round-robin grant) and zero-scrubs every entry after reset or on clear_req.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int unsigned mem_width  = 32,
  parameter  int unsigned mem_depth  = 32,
  parameter  int unsigned NUM_REQ    = 3,
  parameter  bit          INIT_SCRUB = 1'b1,
  parameter  bit          ZERO_REG   = 1'b1,
  localparam int unsigned AW         = addr_w(mem_depth),
  localparam int unsigned IW         = addr_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*AW-1:0]        req_addr,
  input  logic [NUM_REQ*mem_width-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         clear_req,
  output logic                         busy,
  output logic                         rf_we,
  output logic [mem_depth-1:0]         rf_wr_sel,
  output logic [mem_width-1:0]         rf_data_in
);

  state_t               state_q, state_d;
  logic [AW-1:0]        scrub_cnt_q, scrub_cnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 clear_pend_q, clear_pend_d;
  logic [NUM_REQ-1:0]   occ_q, occ_d;
  logic [AW-1:0]        slot_addr_q [NUM_REQ];
  logic [AW-1:0]        slot_addr_d [NUM_REQ];
  logic [mem_width-1:0] slot_data_q [NUM_REQ];
  logic [mem_width-1:0] slot_data_d [NUM_REQ];

  logic                 run;
  logic [NUM_REQ-1:0]   grant_raw, grant, accept;
  logic [IW-1:0]        grant_idx;
  logic                 any_grant;
  logic [AW-1:0]        g_addr;
  logic [mem_width-1:0] g_data;
  logic [MAX_DEPTH-1:0] oh;

  assign run       = (state_q == ST_RUN);
  assign grant     = {NUM_REQ{run}} & grant_raw;
  assign any_grant = |grant;
  assign req_ready = {NUM_REQ{run & ~clear_pend_q & ~reset}} & (~occ_q | grant);
  assign accept    = req_valid & req_ready;
  assign busy      = ~run | (|occ_q) | clear_pend_q;
  assign g_addr    = slot_addr_q[grant_idx];
  assign g_data    = slot_data_q[grant_idx];

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .occ_i       (occ_q),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant_raw),
    .grant_idx_o (grant_idx)
  );

  // Next state: slot refill/drain, pointer advance, scrub sweep and clear handling.
  always_comb begin
    state_d      = state_q;
    scrub_cnt_d  = scrub_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    clear_pend_d = clear_pend_q;
    occ_d        = occ_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        occ_d[i]       = 1'b1;
        slot_addr_d[i] = req_addr[i*AW +: AW];
        slot_data_d[i] = req_data[i*mem_width +: mem_width];
      end else if (grant[i]) begin
        occ_d[i] = 1'b0;
      end
    end

    if (any_grant) rr_ptr_d = IW'((32'(grant_idx) + 1) % NUM_REQ);

    case (state_q)
      ST_SCRUB: begin
        if (32'(scrub_cnt_q) == mem_depth - 1) begin
          state_d     = ST_RUN;
          scrub_cnt_d = '0;
        end else begin
          scrub_cnt_d = scrub_cnt_q + AW'(1);
        end
      end
      default: begin
        // Scrub only once nothing will remain in a slot after this edge.
        if (clear_req || clear_pend_q) begin
          if (occ_d == '0) begin
            state_d      = ST_SCRUB;
            scrub_cnt_d  = '0;
            clear_pend_d = 1'b0;
          end else begin
            clear_pend_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT_SCRUB ? ST_SCRUB : ST_RUN;
      scrub_cnt_q  <= '0;
      rr_ptr_q     <= '0;
      clear_pend_q <= 1'b0;
      occ_q        <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      scrub_cnt_q  <= scrub_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      clear_pend_q <= clear_pend_d;
      occ_q        <= occ_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
    end
  end

  // Write-port mux; driven only from registered state so the file sees it stable by negedge.
  always_comb begin
    rf_we      = 1'b0;
    rf_wr_sel  = '0;
    rf_data_in = '0;
    oh         = onehot(run ? 32'(g_addr) : 32'(scrub_cnt_q));
    if (!reset) begin
      if (!run) begin
        rf_we     = 1'b1;
        rf_wr_sel = oh[mem_depth-1:0];
      end else if (any_grant) begin
        rf_data_in = g_data;
        if (!(ZERO_REG && g_addr == '0) && (32'(g_addr) < mem_depth)) begin
          rf_we     = 1'b1;
          rf_wr_sel = oh[mem_depth-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised plus directed bench for regfile_write_arbiter against a slot/queue reference model.
module tb_regfile_write_arbiter;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int N  = 3;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            clear_req;
  logic            busy;
  logic            rf_we;
  logic [D-1:0]    rf_wr_sel;
  logic [W-1:0]    rf_data_in;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .mem_width(W), .mem_depth(D), .NUM_REQ(N), .INIT_SCRUB(1'b1), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_req(clear_req), .busy(busy),
    .rf_we(rf_we), .rf_wr_sel(rf_wr_sel), .rf_data_in(rf_data_in)
  );

  // Reference model state: one pending entry per source, scrub progress, sticky clear.
  bit          m_scrub;
  int          m_cnt;
  bit          m_occ  [N];
  int          m_addr [N];
  logic [31:0] m_data [N];
  int          m_rr;
  bit          m_cpend;

  bit [N-1:0]  v_drv;
  int          a_drv [N];
  logic [31:0] d_drv [N];
  bit          clr_drv;

  int n_vec = 0;
  int n_mis = 0;
  int we_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (m_occ[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit any_occ();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) r |= m_occ[i];
    return r;
  endfunction

  task automatic model_reset();
    m_scrub = 1'b1; m_cnt = 0; m_rr = 0; m_cpend = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_occ[i] = 1'b0; m_addr[i] = 0; m_data[i] = '0;
    end
  endtask

  task automatic model_step();
    int     g;
    bit [N-1:0] rdy;
    if (m_scrub) begin
      if (m_cnt == D - 1) m_scrub = 1'b0;
      else m_cnt++;
    end else begin
      g = pick();
      for (int i = 0; i < N; i++) rdy[i] = !m_cpend && (!m_occ[i] || i == g);
      if (g >= 0) begin
        m_occ[g] = 1'b0;
        m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (v_drv[i] && rdy[i]) begin
          m_occ[i] = 1'b1; m_addr[i] = a_drv[i]; m_data[i] = d_drv[i];
        end
      end
      if (clr_drv || m_cpend) begin
        if (!any_occ()) begin
          m_scrub = 1'b1; m_cnt = 0; m_cpend = 1'b0;
        end else begin
          m_cpend = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [31:0] e_sel, e_data;
    bit          e_we, e_busy, chk_data;
    bit [N-1:0]  e_rdy;
    int          g;
    e_sel = '0; e_data = '0; e_we = 1'b0; e_rdy = '0; chk_data = 1'b1;
    e_busy = m_scrub || any_occ() || m_cpend;
    if (!reset) begin
      if (m_scrub) begin
        e_we = 1'b1;
        e_sel = 32'd1 << m_cnt;
      end else begin
        g = pick();
        for (int i = 0; i < N; i++) e_rdy[i] = !m_cpend && (!m_occ[i] || i == g);
        if (g >= 0) begin
          e_data = m_data[g];
          if (m_addr[g] != 0) begin
            e_we = 1'b1;
            e_sel = 32'd1 << m_addr[g];
          end else begin
            chk_data = 1'b0;
          end
        end
      end
      check($sformatf("%s.busy", ph), 64'(busy), 64'(e_busy));
    end
    check($sformatf("%s.we", ph), 64'(rf_we), 64'(e_we));
    check($sformatf("%s.sel", ph), 64'(rf_wr_sel), 64'(e_sel));
    if (chk_data) check($sformatf("%s.data", ph), 64'(rf_data_in), 64'(e_data));
    check($sformatf("%s.ready", ph), 64'(req_ready), 64'(e_rdy));
  endtask

  task automatic apply();
    req_valid = v_drv;
    clear_req = clr_drv;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(a_drv[i]);
      req_data[i*W +: W]   = d_drv[i];
    end
  endtask

  task automatic idle();
    v_drv = '0; clr_drv = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_drv[i] = 0; d_drv[i] = '0;
    end
    apply();
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    if (!reset) model_step();
    #1;
    check_outputs(ph);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #2 check_outputs("rst");
    repeat (2) begin
      @(posedge clk); #1 check_outputs("rst");
    end

    // 1: scrub sweep after reset
    reset = 1'b0;
    #1 check_outputs("t1");
    we_cnt = rf_we ? 1 : 0;
    check("t1.sel0", 64'(rf_wr_sel), 64'h1);
    for (int i = 0; i < D + 3; i++) begin
      tick("t1");
      if (rf_we) we_cnt++;
    end
    check("t1.we_cycles", 64'(we_cnt), 64'd32);
    check("t1.ready", 64'(req_ready), 64'h7);

    // 2: three sources at once, round-robin from pointer 0
    v_drv = 3'b111;
    a_drv[0] = 5; a_drv[1] = 6; a_drv[2] = 7;
    d_drv[0] = 32'hAAAA_0001; d_drv[1] = 32'hBBBB_0002; d_drv[2] = 32'hCCCC_0003;
    apply();
    tick("t2");
    check("t2.w5", 64'({rf_wr_sel, rf_data_in}), {32'h20, 32'hAAAA_0001});
    idle();
    tick("t2");
    check("t2.w6", 64'({rf_wr_sel, rf_data_in}), {32'h40, 32'hBBBB_0002});
    tick("t2");
    check("t2.w7", 64'({rf_wr_sel, rf_data_in}), {32'h80, 32'hCCCC_0003});
    tick("t2");
    check("t2.idle_we", 64'(rf_we), 64'd0);

    // 3: one source streaming back-to-back
    for (int k = 0; k < 4; k++) begin
      v_drv = 3'b010; a_drv[1] = 10 + k; d_drv[1] = $urandom;
      check("t3.ready1", 64'(req_ready[1]), 64'd1);
      apply();
      tick("t3");
      check("t3.sel", 64'(rf_wr_sel), 64'(32'd1 << (10 + k)));
    end
    idle();
    repeat (2) tick("t3");

    // 4: write to entry 0 is swallowed
    v_drv = 3'b001; a_drv[0] = 0; d_drv[0] = 32'hFFFF_FFFF;
    apply();
    tick("t4");
    check("t4.we", 64'(rf_we), 64'd0);
    check("t4.ready0", 64'(req_ready[0]), 64'd1);
    idle();
    tick("t4");
    check("t4.busy", 64'(busy), 64'd0);

    // 5: clear while two slots are occupied
    v_drv = 3'b011; a_drv[0] = 20; a_drv[1] = 21;
    d_drv[0] = 32'h1234_5678; d_drv[1] = 32'h9ABC_DEF0;
    apply();
    tick("t5");
    idle();
    clr_drv = 1'b1;
    apply();
    tick("t5");
    check("t5.ready", 64'(req_ready), 64'd0);
    clr_drv = 1'b0;
    apply();
    tick("t5");
    repeat (D) tick("t5");
    check("t5.busy_end", 64'(busy), 64'd0);

    // 6: async reset with slots full
    v_drv = 3'b111;
    for (int i = 0; i < N; i++) begin
      a_drv[i] = 1 + i; d_drv[i] = $urandom;
    end
    apply();
    tick("t6");
    #3 reset = 1'b1;
    #1 check("t6.we_async", 64'(rf_we), 64'd0);
    check("t6.sel_async", 64'(rf_wr_sel), 64'd0);
    model_reset();
    idle();
    check_outputs("t6");
    @(posedge clk); #1 check_outputs("t6");
    reset = 1'b0;
    #1 check_outputs("t6");
    check("t6.sel0", 64'(rf_wr_sel), 64'h1);
    repeat (D + 2) tick("t6");

    // Random traffic
    repeat (900) begin
      for (int i = 0; i < N; i++) begin
        v_drv[i] = ($urandom_range(0, 9) < 6);
        a_drv[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, D - 1));
        d_drv[i] = $urandom;
      end
      clr_drv = ($urandom_range(0, 99) < 2);
      apply();
      tick("rnd");
    end
    idle();
    repeat (D + 8) tick("drain");
    check("drain.busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
